// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl_pkg
// Purpose  : Shared widths and FSM state encoding for the data-memory access
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

   localparam int c_ADDR_W      = 16;
   localparam int c_DATA_W      = 16;
   localparam int c_STALL_CNT_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t c_ST_IDLE = 2'd0;
   localparam state_t c_ST_WAIT = 2'd1;
   localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl_sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + c_ONE;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage controller issuing single-beat req/ack accesses to a
//            multi-cycle data memory and stalling the pipeline meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W   = c_ADDR_W,
   parameter int DATA_W   = c_DATA_W,
   parameter int MAX_WAIT = 31
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        addr_in,
   input  logic [DATA_W-1:0]        wdata_in,
   input  logic                     mem_write_in,
   input  logic                     mem_read_in,
   input  logic                     flush,
   output logic                     stall_n,
   output logic [DATA_W-1:0]        rdata_out,
   output logic                     rdata_valid,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ack,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     timeout,
   output logic [c_STALL_CNT_W-1:0] stall_cnt
);

   localparam int                  c_WCNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [c_WCNT_W-1:0] c_MAX_WAIT = c_WCNT_W'(MAX_WAIT);
   localparam logic [c_WCNT_W-1:0] c_WONE     = c_WCNT_W'(1);

   state_t              r_state;
   logic [c_WCNT_W-1:0] r_wait_cnt;
   logic [c_WCNT_W-1:0] w_wait_cnt_next;
   logic                r_squash;
   logic                w_access;
   logic                w_launch;
   logic                w_in_wait;
   logic                w_timeout_hit;

   assign w_access  = (mem_read_in | mem_write_in) & ~flush;
   assign w_in_wait = (r_state == c_ST_WAIT);
   assign w_launch  = (r_state == c_ST_IDLE) & w_access;
   assign stall_n   = ~(w_launch | w_in_wait);

   // Counter holds the index of the WAIT cycle being entered, so it equals
   // MAX_WAIT exactly in the cycle where timeout first becomes visible.
   always_comb begin
      w_wait_cnt_next = r_wait_cnt;
      if (w_launch) begin
         w_wait_cnt_next = c_WONE;
      end else if (w_in_wait && !mem_ack && (r_wait_cnt != c_MAX_WAIT)) begin
         w_wait_cnt_next = r_wait_cnt + c_WONE;
      end
   end

   assign w_timeout_hit = (w_launch | (w_in_wait & ~mem_ack)) &
                          (w_wait_cnt_next == c_MAX_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_wait_cnt  <= '0;
         r_squash    <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rdata_out   <= '0;
         rdata_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_cnt_next;
         if (w_timeout_hit) begin
            timeout <= 1'b1;
         end
         case (r_state)
            c_ST_IDLE: begin
               if (w_access) begin
                  r_state     <= c_ST_WAIT;
                  mem_req     <= 1'b1;
                  mem_we      <= mem_write_in;
                  mem_addr    <= addr_in;
                  mem_wdata   <= wdata_in;
                  rdata_valid <= 1'b0;
                  r_squash    <= 1'b0;
               end else if (flush) begin
                  rdata_valid <= 1'b0;
               end
            end
            c_ST_WAIT: begin
               // A flushed access still runs to completion; only its load data is dropped.
               if (flush) begin
                  r_squash <= 1'b1;
               end
               if (mem_ack) begin
                  r_state <= c_ST_DONE;
                  mem_req <= 1'b0;
                  if (!mem_we && !(r_squash | flush)) begin
                     rdata_out   <= mem_rdata;
                     rdata_valid <= 1'b1;
                  end
               end
            end
            c_ST_DONE: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   dmem_access_ctrl_sat_counter #(
      .WIDTH (c_STALL_CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (~stall_n),
      .i_clear (1'b0),
      .o_count (stall_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Directed self-checking bench with a transaction-level model of
//            the MEM-stage access controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr_in = '0;
   logic [15:0] wdata_in = '0;
   logic        mem_write_in = 1'b0;
   logic        mem_read_in = 1'b0;
   logic        flush = 1'b0;
   logic        stall_n;
   logic [15:0] rdata_out;
   logic        rdata_valid;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        timeout;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   dmem_access_ctrl #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .MAX_WAIT (MW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .addr_in      (addr_in),
      .wdata_in     (wdata_in),
      .mem_write_in (mem_write_in),
      .mem_read_in  (mem_read_in),
      .flush        (flush),
      .stall_n      (stall_n),
      .rdata_out    (rdata_out),
      .rdata_valid  (rdata_valid),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .timeout      (timeout),
      .stall_cnt    (stall_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a request is either outstanding, just retired
   // (one pipeline-advance cycle), or absent.
   bit          m_busy, m_retired, m_squash, m_we, m_valid, m_timeout;
   int          m_waited, m_stalls;
   logic [15:0] m_addr, m_wdata, m_rdata;
   int          req_cycles, stall_cycles, req_pulses;
   bit          prev_req;

   task automatic model_reset();
      m_busy = 0; m_retired = 0; m_squash = 0; m_we = 0; m_valid = 0;
      m_timeout = 0; m_waited = 0; m_stalls = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
   endtask

   initial begin
      bit e_access, e_stall_n;
      model_reset();
      prev_req = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         e_access  = (mem_read_in | mem_write_in) & ~flush;
         e_stall_n = !(m_busy || (!m_retired && e_access));
         chk("model_stall_n", stall_n, e_stall_n);
         chk("model_mem_req", mem_req, m_busy);
         chk("model_rdata_valid", rdata_valid, m_valid);
         chk("model_rdata_out", rdata_out, m_rdata);
         chk("model_timeout", timeout, m_timeout);
         chk("model_stall_cnt", stall_cnt, m_stalls);
         if (m_busy) begin
            chk("model_mem_we", mem_we, m_we);
            chk("model_mem_addr", mem_addr, m_addr);
            chk("model_mem_wdata", mem_wdata, m_wdata);
         end
         if (mem_req) req_cycles++;
         if (!stall_n) stall_cycles++;
         if (mem_req && !prev_req) req_pulses++;
         prev_req = mem_req;
         if (rst_n) begin
            if (!e_stall_n && m_stalls < 65535) m_stalls++;
            if (m_retired) begin
               m_retired = 0;
            end else if (m_busy) begin
               if (flush) m_squash = 1;
               if (mem_ack) begin
                  m_busy = 0;
                  m_retired = 1;
                  if (!m_we && !m_squash) begin
                     m_rdata = mem_rdata;
                     m_valid = 1;
                  end
               end else begin
                  m_waited++;
                  if (m_waited >= MW) m_timeout = 1;
               end
            end else if (e_access) begin
               m_busy = 1; m_waited = 1; m_squash = 0;
               m_we = mem_write_in; m_addr = addr_in; m_wdata = wdata_in;
               m_valid = 0;
               if (MW <= 1) m_timeout = 1;
            end else if (flush) begin
               m_valid = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #2;
   endtask

   // Presents one access and acks it in WAIT cycle n; returns in the retire cycle.
   task automatic access(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d,
                         input int n, input logic [15:0] rdv, input int flush_at, input bit chk_to);
      mem_write_in = wr; mem_read_in = rd; addr_in = a; wdata_in = d;
      step();
      for (int k = 1; k <= n; k++) begin
         flush     = (k == flush_at);
         mem_ack   = (k == n);
         mem_rdata = (k == n) ? rdv : 16'hDEAD;
         if (chk_to) begin
            look();
            chk("timeout_in_wait", timeout, (k >= MW));
         end
         step();
      end
      flush = 0; mem_ack = 0;
   endtask

   task automatic idle_bus();
      mem_write_in = 0; mem_read_in = 0; flush = 0; mem_ack = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      chk("reset_mem_req", mem_req, 0);
      chk("reset_stall_cnt", stall_cnt, 0);
      chk("reset_rdata_valid", rdata_valid, 0);
      chk("reset_timeout", timeout, 0);
      chk("reset_stall_n", stall_n, 1);
      step();
      rst_n = 1;
      step();

      // Load, acked in the third WAIT cycle
      req_cycles = 0; stall_cycles = 0;
      access(0, 1, 16'h0040, 16'h0000, 3, 16'hBEEF, 0, 0);
      look();
      chk("load_rdata_out", rdata_out, 16'hBEEF);
      chk("load_rdata_valid", rdata_valid, 1);
      chk("load_done_stall_n", stall_n, 1);
      chk("load_stall_cnt", stall_cnt, 4);
      chk("load_req_cycles", req_cycles, 3);
      chk("load_stall_cycles", stall_cycles, 4);
      step();
      idle_bus();

      // Store, acked in the first WAIT cycle
      req_cycles = 0; stall_cycles = 0;
      access(1, 0, 16'h0100, 16'h1234, 1, 16'h0000, 0, 0);
      look();
      chk("store_rdata_valid", rdata_valid, 0);
      chk("store_stall_cycles", stall_cycles, 2);
      chk("store_req_cycles", req_cycles, 1);
      chk("store_stall_cnt", stall_cnt, 6);
      step();
      idle_bus();

      // Stray ack in IDLE, then a flushed load in IDLE, then both strobes
      mem_ack = 1;
      step();
      mem_ack = 0; mem_read_in = 1; flush = 1; addr_in = 16'h0DEF;
      look();
      chk("idle_flush_stall_n", stall_n, 1);
      step();
      idle_bus();
      access(1, 1, 16'h0150, 16'h4321, 1, 16'hFFFF, 0, 0);
      look();
      chk("both_strobes_valid", rdata_valid, 0);
      step();
      idle_bus();

      // Back-to-back load then store
      req_pulses = 0;
      access(0, 1, 16'h0200, 16'h0000, 1, 16'h5A5A, 0, 0);
      look();
      chk("b2b_done_no_req", mem_req, 0);
      chk("b2b_load_data", rdata_out, 16'h5A5A);
      step();
      access(1, 0, 16'h0202, 16'h7777, 1, 16'h0000, 0, 0);
      look();
      chk("b2b_req_pulses", req_pulses, 2);
      step();
      idle_bus();

      // Flush during WAIT of a load
      access(0, 1, 16'h0300, 16'h0000, 2, 16'hAAAA, 1, 0);
      look();
      chk("flush_wait_valid", rdata_valid, 0);
      chk("flush_wait_rdata_kept", rdata_out, 16'h5A5A);
      chk("flush_wait_req_done", mem_req, 0);
      step();
      idle_bus();
      look();
      chk("flush_idle_stall_n", stall_n, 1);

      // Timeout with MAX_WAIT=4: six silent WAIT cycles then ack
      step();
      chk("pre_timeout", timeout, 0);
      access(0, 1, 16'h0400, 16'h0000, 7, 16'hC0DE, 0, 1);
      look();
      chk("timeout_done", timeout, 1);
      chk("timeout_load_data", rdata_out, 16'hC0DE);
      chk("timeout_load_valid", rdata_valid, 1);
      step();
      idle_bus();
      look();
      chk("timeout_sticky", timeout, 1);

      // Asynchronous reset in the middle of WAIT
      step();
      mem_read_in = 1; addr_in = 16'h0500;
      step();
      step();
      chk("pre_reset_req", mem_req, 1);
      #1;
      rst_n = 0;
      #1;
      chk("async_reset_mem_req", mem_req, 0);
      chk("async_reset_stall_cnt", stall_cnt, 0);
      chk("async_reset_timeout", timeout, 0);
      chk("async_reset_valid", rdata_valid, 0);
      idle_bus();
      step();
      rst_n = 1;
      look();
      chk("post_reset_stall_n", stall_n, 1);
      chk("post_reset_mem_req", mem_req, 0);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
